trig_frame_tim: RTL and testbench
=================================

Name: trig_frame_tim

Overview:
- Parametrised, triggered video frame timing generator.
- Each accepted trigger produces one full frame: a programmable number of lines, each with hsync, vsync and data-enable windows.
- Sits between the capture/trigger controller and the video output formatter.
- Adds active-area data enable, polarity control, config shadowing, back-to-back triggering and abort.

Parameters:
- HW, 16, width of horizontal timing fields and the horizontal counter
- VW, 12, width of vertical timing fields and the line counter
- SW, 8, width of the hsync pulse-width field

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  clock enable; counters advance only on clk edges with ena=1
- trig  in  1  frame trigger, single-cycle pulse, sampled on every clk regardless of ena
- abort  in  1  synchronous stop, sampled on every clk
- Thsync  in  SW  hsync width in enabled cycles (0 = no hsync)
- Thlen  in  HW  line period minus 1
- Thact_start  in  HW  first active pixel position (h_cnt)
- Thact_len  in  HW  active pixels per line
- Tvlines  in  VW  lines per frame (0 treated as 1)
- Tvsync  in  VW  vsync width in lines (0 = no vsync)
- Tvact_start  in  VW  first active line (v_cnt)
- Tvact_len  in  VW  active lines per frame
- hs_pol  in  1  1 = hsync active-high
- vs_pol  in  1  1 = vsync active-high
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- daten  out  1  data enable, always active-high
- busy  out  1  frame in progress
- frame_done  out  1  one-clk pulse at normal frame completion
- line_cnt  out  VW  current v_cnt

Behaviour:
- Reset: state IDLE; h_cnt=0, v_cnt=0, pending=0, shadows=0.
- Reset outputs: hsync=~hs_pol and vsync=~vs_pol (combinational XOR of inactive registers), daten=0, busy=0, frame_done=0, line_cnt=0.
- Trigger latch `pending`:
  - Set by trig on any clk.
  - Cleared when a frame is launched, or by abort.
  - One deep: additional triggers while pending=1 are merged.
- States:
  - IDLE: on an ena cycle with pending=1, go to RUN. Set h_cnt=0 and v_cnt=0, load the shadow config from the inputs, clear pending.
  - RUN, ena cycle, h_cnt<Thlen_s: h_cnt+1.
  - RUN, ena cycle, h_cnt==Thlen_s and v_cnt<Tvlines_s-1: h_cnt=0, v_cnt+1.
  - RUN, ena cycle, h_cnt==Thlen_s and v_cnt==Tvlines_s-1: frame end. Set frame_done=1 for this clk. If pending=1, relaunch immediately (h=0, v=0, reload shadows, clear pending, stay in RUN); otherwise go to IDLE.
- Configuration:
  - All timing, polarity and length fields are used only through shadow registers captured at launch.
  - Input changes mid-frame have no effect until the next launch.
- Output decode:
  - Computed from the registered state and counters, then registered. Outputs therefore lag the counters by exactly one clk.
  - hs_i = RUN & (h_cnt < Thsync_s) (zero-extended compare).
  - vs_i = RUN & (v_cnt < Tvsync_s).
  - de_i = RUN & (h_cnt >= Thact_start_s) & (h_cnt < Thact_start_s+Thact_len_s) & (v_cnt >= Tvact_start_s) & (v_cnt < Tvact_start_s+Tvact_len_s).
  - Window sums are computed in HW+1 / VW+1 bits with no wrap. Windows extending past Thlen or Tvlines are clipped naturally.
  - hsync = hs_r ^ ~hs_pol_s and vsync = vs_r ^ ~vs_pol_s, where the polarity shadows load at launch.
  - busy = (state==RUN), registered with the same one-clk lag.
  - line_cnt = v_cnt, direct.
- ena=0: counters, state and pending-consumption hold. Outputs keep their decoded values; frame_done is not re-asserted.
- abort has highest priority:
  - Next clk: state=IDLE, counters=0, pending=0.
  - A trig in the same clk as abort is discarded.
  - No frame_done.
  - Outputs go inactive one clk later.
- Async reset mid-frame: everything returns to reset values immediately.

Test Plan:
- Thlen=9, Thsync=2, Tvlines=3, Tvsync=1, act h 3..6 (start 3, len 4), v 1..1 (start 1, len 1), ena=1, pols=1, single trig.
  - busy for 30 clks.
  - hsync high 2 clks every 10.
  - vsync high for the first 10 clks.
  - daten high for clks 13–16 of the frame.
  - frame_done pulse once; then IDLE.
- Same config with a second trig during frame 1 → frame 2 starts the clk after frame_done with no idle gap. Three triggers during frame 1 → only one extra frame.
- ena toggling 1/0 every clk, same config → every output high time doubles in clks; frame lasts 60 clks; counts per enabled cycle are unchanged.
- hs_pol=0, vs_pol=0 → idle level hsync=vsync=1, pulses low; changing Thsync to 5 mid-frame → width stays 2 until the next frame, then 5.
- abort at line 1, h=4 with trig in the same clk → outputs inactive 2 clks later, no frame_done, busy=0, no relaunch.
- Boundaries:
  - Tvlines=0 → single-line frame.
  - Thsync=0, Tvsync=0 → syncs never active.
  - Thact_start=8, Thact_len=5 with Thlen=9 → daten only at h=8,9.
  - Async reset mid-frame → all outputs at reset values.

Source files
------------

// File: rtl/trig_frame_tim.sv
// Triggered video frame timing generator: each accepted trigger emits one frame of
// hsync/vsync/daten windows. Config is shadowed at launch; decoded outputs lag counters by one clk.
module trig_frame_tim #(
    parameter int HW = 16,
    parameter int VW = 12,
    parameter int SW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic          trig,
    input  logic          abort,
    input  logic [SW-1:0] Thsync,
    input  logic [HW-1:0] Thlen,
    input  logic [HW-1:0] Thact_start,
    input  logic [HW-1:0] Thact_len,
    input  logic [VW-1:0] Tvlines,
    input  logic [VW-1:0] Tvsync,
    input  logic [VW-1:0] Tvact_start,
    input  logic [VW-1:0] Tvact_len,
    input  logic          hs_pol,
    input  logic          vs_pol,
    output logic          hsync,
    output logic          vsync,
    output logic          daten,
    output logic          busy,
    output logic          frame_done,
    output logic [VW-1:0] line_cnt
);

    localparam int HSW = (HW > SW) ? HW : SW;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_n;
    logic [HW-1:0] h_cnt, h_cnt_n;
    logic [VW-1:0] v_cnt, v_cnt_n;
    logic          pending, pending_n;
    logic          line_end, frame_end, launch;
    logic [VW-1:0] v_last;

    logic [SW-1:0] thsync_s;
    logic [HW-1:0] thlen_s, thact_start_s, thact_len_s;
    logic [VW-1:0] tvlines_s, tvsync_s, tvact_start_s, tvact_len_s;
    logic          hs_pol_s, vs_pol_s;

    logic          hs_i, vs_i, de_i;
    logic [HW:0]   h_end;
    logic [VW:0]   v_end;
    logic          hs_r, vs_r, de_r, busy_r, done_r, hs_pol_r, vs_pol_r;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        v_last    = (tvlines_s == '0) ? '0 : tvlines_s - VW'(1);
        line_end  = (state == RUN) && ena && (h_cnt == thlen_s);
        frame_end = line_end && (v_cnt == v_last) && !abort;
        launch    = !abort && ena && pending && ((state == IDLE) || frame_end);

        state_n   = state;
        h_cnt_n   = h_cnt;
        v_cnt_n   = v_cnt;
        pending_n = trig || (pending && !launch);

        if (abort) begin
            // Abort wins over everything, including a trigger in the same clk.
            state_n   = IDLE;
            h_cnt_n   = '0;
            v_cnt_n   = '0;
            pending_n = 1'b0;
        end else if (launch) begin
            state_n = RUN;
            h_cnt_n = '0;
            v_cnt_n = '0;
        end else if (frame_end) begin
            state_n = IDLE;
            h_cnt_n = '0;
            v_cnt_n = '0;
        end else if (line_end) begin
            h_cnt_n = '0;
            v_cnt_n = v_cnt + VW'(1);
        end else if ((state == RUN) && ena) begin
            h_cnt_n = h_cnt + HW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            h_cnt   <= '0;
            v_cnt   <= '0;
            pending <= 1'b0;
        end else begin
            state   <= state_n;
            h_cnt   <= h_cnt_n;
            v_cnt   <= v_cnt_n;
            pending <= pending_n;
        end
    end

    // NOTE: shadows get a defined reset value so the idle decode never depends on X config.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thsync_s      <= '0;
            thlen_s       <= '0;
            thact_start_s <= '0;
            thact_len_s   <= '0;
            tvlines_s     <= '0;
            tvsync_s      <= '0;
            tvact_start_s <= '0;
            tvact_len_s   <= '0;
            hs_pol_s      <= 1'b0;
            vs_pol_s      <= 1'b0;
        end else if (launch) begin
            thsync_s      <= Thsync;
            thlen_s       <= Thlen;
            thact_start_s <= Thact_start;
            thact_len_s   <= Thact_len;
            tvlines_s     <= Tvlines;
            tvsync_s      <= Tvsync;
            tvact_start_s <= Tvact_start;
            tvact_len_s   <= Tvact_len;
            hs_pol_s      <= hs_pol;
            vs_pol_s      <= vs_pol;
        end
    end

    // Window ends carry one extra bit so start+len never wraps.
    always_comb begin
        h_end = {1'b0, thact_start_s} + {1'b0, thact_len_s};
        v_end = {1'b0, tvact_start_s} + {1'b0, tvact_len_s};
        hs_i  = (state == RUN) && (HSW'(h_cnt) < HSW'(thsync_s));
        vs_i  = (state == RUN) && (v_cnt < tvsync_s);
        de_i  = (state == RUN)
              && (h_cnt >= thact_start_s) && ({1'b0, h_cnt} < h_end)
              && (v_cnt >= tvact_start_s) && ({1'b0, v_cnt} < v_end);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_r     <= 1'b0;
            vs_r     <= 1'b0;
            de_r     <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            hs_pol_r <= 1'b0;
            vs_pol_r <= 1'b0;
        end else begin
            hs_r     <= hs_i;
            vs_r     <= vs_i;
            de_r     <= de_i;
            busy_r   <= (state == RUN);
            done_r   <= frame_end;
            hs_pol_r <= hs_pol_s;
            vs_pol_r <= vs_pol_s;
        end
    end

    // While idle the inactive level follows the live polarity inputs, so reset idles at ~pol.
    assign hsync      = hs_r ^ ~(busy_r ? hs_pol_r : hs_pol);
    assign vsync      = vs_r ^ ~(busy_r ? vs_pol_r : vs_pol);
    assign daten      = de_r;
    assign busy       = busy_r;
    assign frame_done = done_r;
    assign line_cnt   = v_cnt;

endmodule

// File: tb/tb_trig_frame_tim.sv
// Self-checking bench for trig_frame_tim: directed frame table, hand-written multi-cycle
// sequences and randomized traffic, all compared against a position-based frame model.
module tb_trig_frame_tim;

    localparam int HW = 16;
    localparam int VW = 12;
    localparam int SW = 8;

    logic          clk, rst_n, ena, trig, abort;
    logic [SW-1:0] Thsync;
    logic [HW-1:0] Thlen, Thact_start, Thact_len;
    logic [VW-1:0] Tvlines, Tvsync, Tvact_start, Tvact_len;
    logic          hs_pol, vs_pol;
    logic          hsync, vsync, daten, busy, frame_done;
    logic [VW-1:0] line_cnt;

    trig_frame_tim #(.HW(HW), .VW(VW), .SW(SW)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .trig(trig), .abort(abort),
        .Thsync(Thsync), .Thlen(Thlen), .Thact_start(Thact_start), .Thact_len(Thact_len),
        .Tvlines(Tvlines), .Tvsync(Tvsync), .Tvact_start(Tvact_start), .Tvact_len(Tvact_len),
        .hs_pol(hs_pol), .vs_pol(vs_pol),
        .hsync(hsync), .vsync(vsync), .daten(daten), .busy(busy),
        .frame_done(frame_done), .line_cnt(line_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int thsync, thlen, has, hal, lines, tvsync, vas, val;
        bit hpol, vpol;
    } cfg_t;

    typedef struct {
        cfg_t c;
        int   ena_mode;
        int   x_busy, x_hs, x_vs, x_de, x_done;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    // Frame model: a frame is a run of positions p = 0 .. period*lines-1 stepped per enabled cycle.
    cfg_t m_cfg;
    bit   m_run, m_pend;
    int   m_p;
    bit   e_hs, e_vs, e_de, e_busy, e_done, e_hpol, e_vpol;

    int   ena_mode;
    int   cnt_busy, cnt_hs, cnt_vs, cnt_de, cnt_done, cnt_fall;
    bit   prev_busy;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic cfg_t read_inputs();
        cfg_t c;
        c.thsync = int'(Thsync);    c.thlen = int'(Thlen);
        c.has    = int'(Thact_start); c.hal = int'(Thact_len);
        c.lines  = int'(Tvlines);   c.tvsync = int'(Tvsync);
        c.vas    = int'(Tvact_start); c.val = int'(Tvact_len);
        c.hpol   = hs_pol;          c.vpol = vs_pol;
        return c;
    endfunction

    task automatic apply_cfg(input cfg_t c);
        Thsync      = SW'(c.thsync);
        Thlen       = HW'(c.thlen);
        Thact_start = HW'(c.has);
        Thact_len   = HW'(c.hal);
        Tvlines     = VW'(c.lines);
        Tvsync      = VW'(c.tvsync);
        Tvact_start = VW'(c.vas);
        Tvact_len   = VW'(c.val);
        hs_pol      = c.hpol;
        vs_pol      = c.vpol;
    endtask

    function automatic cfg_t mk_cfg(int thsync, int thlen, int has, int hal, int lines,
                                    int tvsync, int vas, int val, bit pol);
        cfg_t c;
        c.thsync = thsync; c.thlen = thlen; c.has = has; c.hal = hal;
        c.lines = lines; c.tvsync = tvsync; c.vas = vas; c.val = val;
        c.hpol = pol; c.vpol = pol;
        return c;
    endfunction

    function automatic cfg_t rand_cfg();
        cfg_t c;
        c.thsync = $urandom_range(0, 12); c.thlen = $urandom_range(0, 11);
        c.has    = $urandom_range(0, 12); c.hal   = $urandom_range(0, 12);
        c.lines  = $urandom_range(0, 4);  c.tvsync = $urandom_range(0, 5);
        c.vas    = $urandom_range(0, 4);  c.val   = $urandom_range(0, 4);
        c.hpol   = 1'($urandom_range(0, 1)); c.vpol = 1'($urandom_range(0, 1));
        return c;
    endfunction

    task automatic model_reset();
        m_cfg  = mk_cfg(0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
        m_run  = 1'b0; m_pend = 1'b0; m_p = 0;
        e_hs = 0; e_vs = 0; e_de = 0; e_busy = 0; e_done = 0; e_hpol = 0; e_vpol = 0;
    endtask

    // Called just after each active edge with the inputs that edge sampled.
    task automatic model_step();
        int  per, nl, h, v;
        bit  fire;
        per    = m_cfg.thlen + 1;
        nl     = (m_cfg.lines == 0) ? 1 : m_cfg.lines;
        h      = m_p % per;
        v      = m_p / per;
        e_busy = m_run;
        e_hs   = m_run && (h < m_cfg.thsync);
        e_vs   = m_run && (v < m_cfg.tvsync);
        e_de   = m_run && (h >= m_cfg.has) && (h < m_cfg.has + m_cfg.hal)
                       && (v >= m_cfg.vas) && (v < m_cfg.vas + m_cfg.val);
        e_done = m_run && ena && !abort && (m_p == per * nl - 1);
        e_hpol = m_cfg.hpol;
        e_vpol = m_cfg.vpol;
        if (abort) begin
            m_run = 1'b0; m_p = 0; m_pend = 1'b0;
        end else begin
            fire = ena && m_pend && (!m_run || e_done);
            if (m_run && ena) begin
                if (e_done) m_run = 1'b0;
                else        m_p++;
            end
            if (fire) begin
                m_run = 1'b1; m_p = 0; m_cfg = read_inputs();
            end
            m_pend = trig || (m_pend && !fire);
        end
    endtask

    task automatic check_model();
        bit exp_h, exp_v;
        int exp_line;
        exp_h    = e_hs ^ ~(e_busy ? e_hpol : hs_pol);
        exp_v    = e_vs ^ ~(e_busy ? e_vpol : vs_pol);
        exp_line = m_run ? (m_p / (m_cfg.thlen + 1)) : 0;
        check("hsync", int'(hsync), int'(exp_h));
        check("vsync", int'(vsync), int'(exp_v));
        check("daten", int'(daten), int'(e_de));
        check("busy", int'(busy), int'(e_busy));
        check("frame_done", int'(frame_done), int'(e_done));
        check("line_cnt", int'(line_cnt), exp_line);
    endtask

    task automatic clear_counts();
        cnt_busy = 0; cnt_hs = 0; cnt_vs = 0; cnt_de = 0; cnt_done = 0; cnt_fall = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        check_model();
        cnt_busy += int'(busy);
        cnt_hs   += int'(hsync == hs_pol);
        cnt_vs   += int'(vsync == vs_pol);
        cnt_de   += int'(daten);
        cnt_done += int'(frame_done);
        if (prev_busy && !busy) cnt_fall++;
        prev_busy = busy;
        case (ena_mode)
            0:       ena = 1'b1;
            1:       ena = ~ena;
            default: ena = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic pulse_trig();
        trig = 1'b1;
        tick();
        trig = 1'b0;
    endtask

    vec_t vecs[8];
    cfg_t base;
    bit   found;

    initial begin
        rst_n = 1'b0; ena = 1'b1; trig = 1'b0; abort = 1'b0;
        ena_mode = 0; prev_busy = 1'b0;
        base = mk_cfg(2, 9, 3, 4, 3, 1, 1, 1, 1'b1);
        apply_cfg(base);
        model_reset();
        clear_counts();

        // Stimulus table: config, ena pattern, expected active clks per output over one frame.
        vecs[0] = '{c: base, ena_mode: 0, x_busy: 30, x_hs: 6, x_vs: 10, x_de: 4, x_done: 1};
        vecs[1] = '{c: mk_cfg(2, 9, 3, 4, 0, 1, 0, 1, 1'b1), ena_mode: 0,
                    x_busy: 10, x_hs: 2, x_vs: 10, x_de: 4, x_done: 1};
        vecs[2] = '{c: mk_cfg(0, 9, 3, 4, 3, 0, 1, 1, 1'b1), ena_mode: 0,
                    x_busy: 30, x_hs: 0, x_vs: 0, x_de: 4, x_done: 1};
        vecs[3] = '{c: mk_cfg(2, 9, 8, 5, 3, 1, 0, 3, 1'b1), ena_mode: 0,
                    x_busy: 30, x_hs: 6, x_vs: 10, x_de: 6, x_done: 1};
        vecs[4] = '{c: base, ena_mode: 1, x_busy: 60, x_hs: 12, x_vs: 20, x_de: 8, x_done: 1};
        vecs[5] = '{c: mk_cfg(2, 9, 3, 4, 3, 1, 1, 1, 1'b0), ena_mode: 0,
                    x_busy: 30, x_hs: 6, x_vs: 10, x_de: 4, x_done: 1};
        vecs[6] = '{c: mk_cfg(200, 9, 3, 4, 3, 5, 0, 100, 1'b1), ena_mode: 0,
                    x_busy: 30, x_hs: 30, x_vs: 30, x_de: 12, x_done: 1};
        vecs[7] = '{c: mk_cfg(1, 0, 0, 1, 4, 2, 1, 2, 1'b1), ena_mode: 0,
                    x_busy: 4, x_hs: 4, x_vs: 2, x_de: 2, x_done: 1};

        // Reset state
        @(negedge clk);
        check("rst_hsync", int'(hsync), 0);
        check("rst_vsync", int'(vsync), 0);
        check("rst_daten", int'(daten), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(frame_done), 0);
        check("rst_line", int'(line_cnt), 0);
        #2 rst_n = 1'b1;
        repeat (3) tick();

        foreach (vecs[i]) begin
            apply_cfg(vecs[i].c);
            ena_mode = vecs[i].ena_mode;
            clear_counts();
            pulse_trig();
            repeat (150) tick();
            check($sformatf("v%0d_busy", i), cnt_busy, vecs[i].x_busy);
            check($sformatf("v%0d_hs", i), cnt_hs, vecs[i].x_hs);
            check($sformatf("v%0d_vs", i), cnt_vs, vecs[i].x_vs);
            check($sformatf("v%0d_de", i), cnt_de, vecs[i].x_de);
            check($sformatf("v%0d_done", i), cnt_done, vecs[i].x_done);
            ena_mode = 0;
        end

        // Back-to-back: one extra trigger mid-frame gives two gapless frames.
        apply_cfg(base);
        clear_counts();
        pulse_trig();
        repeat (10) tick();
        pulse_trig();
        repeat (120) tick();
        check("b2b_busy", cnt_busy, 60);
        check("b2b_done", cnt_done, 2);
        check("b2b_gap", cnt_fall, 1);
        check("b2b_de", cnt_de, 8);

        // Three triggers in frame 1 merge into a single extra frame.
        clear_counts();
        pulse_trig();
        repeat (5) tick();
        pulse_trig();
        repeat (3) tick();
        pulse_trig();
        repeat (3) tick();
        pulse_trig();
        repeat (120) tick();
        check("merge_busy", cnt_busy, 60);
        check("merge_done", cnt_done, 2);
        check("merge_gap", cnt_fall, 1);

        // Active-low syncs; Thsync change mid-frame only takes effect on the relaunch.
        apply_cfg(mk_cfg(2, 9, 3, 4, 3, 1, 1, 1, 1'b0));
        repeat (2) tick();
        check("lowpol_idle_h", int'(hsync), 1);
        check("lowpol_idle_v", int'(vsync), 1);
        clear_counts();
        pulse_trig();
        repeat (5) tick();
        Thsync = SW'(5);
        pulse_trig();
        repeat (120) tick();
        check("shadow_hs_low", cnt_hs, 21);
        check("shadow_busy", cnt_busy, 60);
        check("shadow_done", cnt_done, 2);

        // Abort at line 1, h=4 with a simultaneous trigger.
        apply_cfg(base);
        clear_counts();
        pulse_trig();
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (line_cnt == VW'(1)) found = 1'b1;
        end
        check("abort_wait", int'(found), 1);
        repeat (4) tick();
        abort = 1'b1; trig = 1'b1;
        tick();
        abort = 1'b0; trig = 1'b0;
        check("abort_line", int'(line_cnt), 0);
        tick();
        check("abort_busy", int'(busy), 0);
        check("abort_daten", int'(daten), 0);
        check("abort_hsync", int'(hsync), 0);
        check("abort_vsync", int'(vsync), 0);
        repeat (40) tick();
        check("abort_nodone", cnt_done, 0);
        check("abort_norelaunch", int'(busy), 0);

        // Asynchronous reset mid-frame.
        apply_cfg(base);
        pulse_trig();
        repeat (15) tick();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_busy", int'(busy), 0);
        check("arst_hsync", int'(hsync), 0);
        check("arst_vsync", int'(vsync), 0);
        check("arst_daten", int'(daten), 0);
        check("arst_done", int'(frame_done), 0);
        check("arst_line", int'(line_cnt), 0);
        tick();
        #2 rst_n = 1'b1;
        repeat (20) tick();
        check("arst_stays_idle", int'(busy), 0);

        // Randomized traffic against the model.
        ena_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            trig  = ($urandom_range(0, 15) == 0);
            abort = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 7) == 0) apply_cfg(rand_cfg());
            tick();
        end
        trig = 1'b0; abort = 1'b0; ena_mode = 0;
        repeat (120) tick();
        check("final_idle", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
